// File: rtl/hex7seg_scan.sv
// hex7seg_scan: time-multiplexed N-digit hex seven-segment driver.
// It scans one digit per slot and supports per-digit decimal points and
// leading-zero blanking. New data is loaded without tearing: it reaches the
// display only at a frame start.
module hex7seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [0:6]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;

  // Hex nibble to active-low segments, bit 6 = a ... bit 0 = g
  function automatic logic [6:0] decode_al(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Apply segment polarity to an active-low pattern
  function automatic logic [6:0] seg_pol(input logic [6:0] al);
    return (SEG_ACT_LOW != 0) ? al : ~al;
  endfunction

  // Apply decimal-point polarity to a lit flag (1 = lit)
  function automatic logic dp_pol(input logic lit);
    return (SEG_ACT_LOW != 0) ? ~lit : lit;
  endfunction

  // Apply anode polarity to an active-high one-hot select
  function automatic logic [NUM_DIGITS-1:0] an_pol(input logic [NUM_DIGITS-1:0] oh);
    return (AN_ACT_LOW != 0) ? ~oh : oh;
  endfunction

  logic [PW-1:0]           psc;
  logic [IW-1:0]           idx;
  logic                    pend;
  logic [4*NUM_DIGITS-1:0] pending_val, active_val;
  logic [NUM_DIGITS-1:0]   pending_dp, active_dp;

  logic                    tc, boundary, swap;
  logic [PW-1:0]           psc_nxt;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] act_val_nxt;
  logic [NUM_DIGITS-1:0]   act_dp_nxt;

  // Scan counters and frame-synchronous data swap, next-state view
  always_comb begin
    tc          = (psc == PSC_LAST);
    boundary    = tc && (idx == IDX_LAST);
    swap        = boundary && pend;
    psc_nxt     = tc ? '0 : psc + 1'b1;
    idx_nxt     = idx;
    if (tc) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    act_val_nxt = swap ? pending_val : active_val;
    act_dp_nxt  = swap ? pending_dp  : active_dp;
  end

  // Prescaler, digit index and load-pending flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc  <= '0;
      idx  <= '0;
      pend <= 1'b0;
    end else begin
      psc <= psc_nxt;
      idx <= idx_nxt;
      if (load)      pend <= 1'b1;
      else if (swap) pend <= 1'b0;
    end
  end

  // Pending and active data; a load in the swap cycle lands in pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_val <= '0;
      pending_dp  <= '0;
      active_val  <= '0;
      active_dp   <= '0;
    end else begin
      if (load) begin
        pending_val <= value;
        pending_dp  <= dp_in;
      end
      if (swap) begin
        active_val <= pending_val;
        active_dp  <= pending_dp;
      end
    end
  end

  logic [NUM_DIGITS-1:0] blank_p0;
  logic                  zrun;

  // Leading-zero blanking: a digit blanks when it and every digit above it is 0 with no dp
  always_comb begin
    blank_p0 = '0;
    zrun     = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun        = zrun && (act_val_nxt[4*k +: 4] == 4'h0) && !act_dp_nxt[k];
      blank_p0[k] = lz_en && zrun && (k != 0);
    end
  end

  logic [3:0]            nib_p0;
  logic                  dpsel_p0, blk_p0;
  logic [NUM_DIGITS-1:0] oh_p0, an_p0;
  logic [6:0]            seg_p0;
  logic                  dp_p0;

  // Select and decode the digit that the next cycle's slot shows
  always_comb begin
    nib_p0   = '0;
    dpsel_p0 = 1'b0;
    blk_p0   = 1'b0;
    oh_p0    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib_p0   = act_val_nxt[4*k +: 4];
        dpsel_p0 = act_dp_nxt[k];
        blk_p0   = blank_p0[k];
        oh_p0[k] = 1'b1;
      end
    end
    seg_p0 = blk_p0 ? SEG_OFF : seg_pol(decode_al(nib_p0));
    dp_p0  = blk_p0 ? DP_OFF : dp_pol(dpsel_p0);
    an_p0  = (blk_p0 || (psc_nxt == '0)) ? AN_OFF : an_pol(oh_p0);
  end

  // Output register stage; the first cycle of each slot keeps anodes off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display <= SEG_OFF;
      dp      <= DP_OFF;
      an      <= AN_OFF;
      frame   <= 1'b0;
    end else begin
      display <= seg_p0;
      dp      <= dp_p0;
      an      <= an_p0;
      frame   <= boundary;
    end
  end

endmodule

// File: tb/tb_hex7seg_scan.sv
// Directed bench for hex7seg_scan with 4 digits and 4 clocks per slot.
module tb_hex7seg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [0:6]  display;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int tests = 0;
  int fails = 0;

  logic [6:0] cap_seg[16];
  logic       cap_dp[16];
  logic [3:0] cap_an[16];
  logic       cap_frame[16];

  hex7seg_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .display(display), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_tab(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] e_an(input int i, input logic [3:0] blank);
    int s;
    s = i / 4;
    if ((i % 4) == 0 || blank[s]) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [6:0] e_seg(input int i, input logic [15:0] v, input logic [3:0] blank);
    int s;
    s = i / 4;
    if (blank[s]) return 7'h7F;
    return seg_tab(v[4*s +: 4]);
  endfunction

  function automatic logic e_dp(input int i, input logic [3:0] d, input logic [3:0] blank);
    int s;
    s = i / 4;
    if (blank[s]) return 1'b1;
    return ~d[s];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (frame === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic capture_frame();
    for (int i = 0; i < 16; i++) begin
      cap_seg[i]   = display;
      cap_dp[i]    = dp;
      cap_an[i]    = an;
      cap_frame[i] = frame;
      if (i < 15) tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    tick(); tick();
    tests++;
    if (display !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: display=%b dp=%b an=%b frame=%b, want 1111111 1 1111 0", display, dp, an, frame);
    end
    reset = 1'b0;
    do_load(16'h5555, 4'b0000);
    tick(); tick(); tick(); tick();
    #1 reset = 1'b1;
    #1;
    tests++;
    if (display !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: display=%b dp=%b an=%b frame=%b, want 1111111 1 1111 0", display, dp, an, frame);
    end
    tick();
    reset = 1'b0;
    tests++;
    if (an !== 4'hF) begin
      fails++;
      $display("FAIL reset_ghost: an=%b, want 1111", an);
    end
    tick();
    tests++;
    if (an !== 4'b1110 || display !== 7'b0000001 || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_digit: an=%b display=%b dp=%b, want 1110 0000001 1", an, display, dp);
    end
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_frame_timeout: frame=%b, want 1", frame);
    end
    capture_frame();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cap_an[i] !== e_an(i, 4'b0000) || cap_seg[i] !== e_seg(i, 16'h0000, 4'b0000) || cap_dp[i] !== e_dp(i, 4'b0000, 4'b0000)) begin
        fails++;
        $display("FAIL reset_discard cyc %0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", i, cap_an[i], cap_seg[i], cap_dp[i],
                 e_an(i, 4'b0000), e_seg(i, 16'h0000, 4'b0000), e_dp(i, 4'b0000, 4'b0000));
      end
    end
  endtask

  task automatic test_digits(input string name, input logic [15:0] v, input logic [3:0] d, input logic lz, input logic [3:0] blank);
    bit ok;
    lz_en = lz;
    wait_frame(ok);
    tick(); tick();
    do_load(v, d);
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_frame_timeout: frame=%b, want 1", name, frame);
    end
    capture_frame();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cap_an[i] !== e_an(i, blank) || cap_seg[i] !== e_seg(i, v, blank) || cap_dp[i] !== e_dp(i, d, blank)) begin
        fails++;
        $display("FAIL %s cyc %0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", name, i, cap_an[i], cap_seg[i], cap_dp[i],
                 e_an(i, blank), e_seg(i, v, blank), e_dp(i, d, blank));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    lz_en = 1'b0;
    wait_frame(ok);
    tick(); tick();
    do_load(16'h1111, 4'b0000);
    for (int i = 0; i < 12; i++) tick();
    do_load(16'h2222, 4'b0000);
    tests++;
    if (frame !== 1'b1) begin
      fails++;
      $display("FAIL b2b_boundary_frame: frame=%b, want 1", frame);
    end
    capture_frame();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cap_an[i] !== e_an(i, 4'b0000) || cap_seg[i] !== e_seg(i, 16'h1111, 4'b0000) || cap_dp[i] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_first cyc %0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=1", i, cap_an[i], cap_seg[i], cap_dp[i],
                 e_an(i, 4'b0000), e_seg(i, 16'h1111, 4'b0000));
      end
    end
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_frame_timeout: frame=%b, want 1", frame);
    end
    capture_frame();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cap_an[i] !== e_an(i, 4'b0000) || cap_seg[i] !== e_seg(i, 16'h2222, 4'b0000) || cap_dp[i] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_second cyc %0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=1", i, cap_an[i], cap_seg[i], cap_dp[i],
                 e_an(i, 4'b0000), e_seg(i, 16'h2222, 4'b0000));
      end
    end
  endtask

  task automatic test_free_run();
    bit ok;
    lz_en = 1'b0;
    wait_frame(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL free_frame_timeout: frame=%b, want 1", frame);
    end
    for (int i = 1; i <= 48; i++) begin
      tick();
      tests++;
      if (frame !== ((i % 16) == 0)) begin
        fails++;
        $display("FAIL free_frame cyc %0d: frame=%b, want %b", i, frame, ((i % 16) == 0));
      end
      tests++;
      if ((i % 4) == 0) begin
        if (an !== 4'hF) begin
          fails++;
          $display("FAIL free_ghost cyc %0d: an=%b, want 1111", i, an);
        end
      end else if ($countones(~an) != 1) begin
        fails++;
        $display("FAIL free_onehot cyc %0d: an=%b, want exactly one active bit", i, an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits("hex12AF", 16'h12AF, 4'b0000, 1'b0, 4'b0000);
    test_digits("lz00A0",  16'h00A0, 4'b0000, 1'b1, 4'b1100);
    test_digits("lzdp",    16'h0000, 4'b0100, 1'b1, 4'b1000);
    test_back_to_back();
    test_free_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
